// File: rtl/mac_cfg_loader_pkg.sv
// Shared constants and types for the MAC configuration loader.
// Optional parity beat is enabled by defining MAC_CFG_PARITY_EN.
package mac_cfg_loader_pkg;

    localparam int MAC_CONF_WIDTH_DEF = 4;
    localparam int MAC_MIN_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        MAC_CFG_IDLE   = 2'd0,
        MAC_CFG_LOAD   = 2'd1,
        MAC_CFG_COMMIT = 2'd2
    } mac_cfg_state_e;

    // Full configuration word: four accumulator preloads plus the mode bits.
    function automatic int cfg_width(input int conf_w, input int acc_w);
        return 4 * acc_w + conf_w;
    endfunction

    // Data beats needed to cover the word; the last beat may carry padding.
    function automatic int num_beats(input int cfg_w, input int min_w);
        return (cfg_w + min_w - 1) / min_w;
    endfunction

    // Beats per load including the trailing parity beat when enabled.
    function automatic int total_beats(input int nb);
`ifdef MAC_CFG_PARITY_EN
        return nb + 1;
`else
        return nb;
`endif
    endfunction

endpackage

// File: rtl/mac_cfg_shadow.sv
// Beat counter, shadow register and running XOR for the configuration loader.
// With MAC_CFG_PARITY_EN defined the final data beat is stored and a parity
// comparison against the running XOR is provided; otherwise the final beat is
// merged straight from the input lane.
module mac_cfg_shadow
    import mac_cfg_loader_pkg::*;
#(
    parameter int MIN_WIDTH = 8,
    parameter int CFG_WIDTH = 132,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MIN_WIDTH-1:0] data_i,
    input  logic                 accept_i,
    input  logic                 clr_i,
    output logic [CNT_W-1:0]     cnt_o,
    output logic [CFG_WIDTH-1:0] word_o,
    output logic                 par_ok_o
);

    localparam int NUM_BEATS = num_beats(CFG_WIDTH, MIN_WIDTH);
    localparam int LAST_W    = CFG_WIDTH - (NUM_BEATS - 1) * MIN_WIDTH;

    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [NUM_BEATS-2:0][MIN_WIDTH-1:0] body_q, body_d;

    // Beat counter: clears on abort/commit/reject, advances on each accepted beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (accept_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Indexed write of the current beat into its full-width shadow slot.
    always_comb begin
        body_d = body_q;
        for (int k = 0; k < NUM_BEATS - 1; k++) begin
            if (accept_i && cnt_q == CNT_W'(k)) begin
                body_d[k] = data_i;
            end
        end
    end

    // Shadow register.
    always_ff @(posedge clk) begin
        // NOTE: pure data storage has no reset; it is only read after being rewritten by a full load.
        body_q <= body_d;
    end

`ifdef MAC_CFG_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NUM_BEATS - 1);

    logic [LAST_W-1:0]    tail_q, tail_d;
    logic [MIN_WIDTH-1:0] xor_q, xor_d;

    // Store the final (truncated) data beat and fold every data beat into the XOR.
    always_comb begin
        tail_d = tail_q;
        xor_d  = xor_q;
        if (accept_i && cnt_q == LAST_DATA) begin
            tail_d = data_i[LAST_W-1:0];
        end
        if (accept_i && cnt_q < CNT_W'(NUM_BEATS)) begin
            xor_d = (cnt_q == '0) ? data_i : (xor_q ^ data_i);
        end
    end

    // Tail and parity registers.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
        xor_q  <= xor_d;
    end

    assign word_o   = {tail_q, body_q};
    assign par_ok_o = (xor_q == data_i);
`else
    assign word_o   = {data_i[LAST_W-1:0], body_q};
    assign par_ok_o = 1'b1;
`endif

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mac_cfg_loader.sv
// Writer side of the MAC cfg/cset interface: collects narrow beats over a
// valid/ready handshake and commits the full word with a one-cycle strobe.
// cfg only moves on a commit or reset, so the MAC mode bits never glitch.
// Define MAC_CFG_PARITY_EN to require a trailing XOR parity beat.
module mac_cfg_loader
    import mac_cfg_loader_pkg::*;
#(
    parameter  int MAC_CONF_WIDTH = MAC_CONF_WIDTH_DEF,
    parameter  int MAC_MIN_WIDTH  = MAC_MIN_WIDTH_DEF,
    parameter  int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH,
    localparam int CFG_WIDTH      = cfg_width(MAC_CONF_WIDTH, MAC_ACC_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [MAC_MIN_WIDTH-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     abort,
    output logic [CFG_WIDTH-1:0]     cfg,
    output logic                     cset,
    output logic                     busy,
    output logic                     cfg_err
);

    localparam int NUM_BEATS  = num_beats(CFG_WIDTH, MAC_MIN_WIDTH);
    localparam int TOTAL      = total_beats(NUM_BEATS);
    localparam int CNT_W      = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL - 1);

    mac_cfg_state_e       state_q, state_d;
    logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
    logic                 cset_q, cset_d;
    logic [CNT_W-1:0]     cnt;
    logic [CFG_WIDTH-1:0] word;
    logic                 par_ok;
    logic                 accept;
    logic                 clr;

    assign in_ready = !reset && (state_q == MAC_CFG_IDLE || state_q == MAC_CFG_LOAD) && !abort;
    assign accept   = in_valid && in_ready;

    mac_cfg_shadow #(
        .MIN_WIDTH (MAC_MIN_WIDTH),
        .CFG_WIDTH (CFG_WIDTH),
        .CNT_W     (CNT_W)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .data_i   (in_data),
        .accept_i (accept),
        .clr_i    (clr),
        .cnt_o    (cnt),
        .word_o   (word),
        .par_ok_o (par_ok)
    );

`ifdef MAC_CFG_PARITY_EN
    logic err_q, err_d;
`endif

    // Next state, commit of cfg/cset, and counter clear.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cset_d  = 1'b0;
        clr     = 1'b0;
`ifdef MAC_CFG_PARITY_EN
        err_d   = err_q;
`endif
        case (state_q)
            MAC_CFG_IDLE, MAC_CFG_LOAD: begin
                if (state_q == MAC_CFG_LOAD && abort) begin
                    state_d = MAC_CFG_IDLE;
                    clr     = 1'b1;
                end else if (accept) begin
`ifdef MAC_CFG_PARITY_EN
                    if (cnt == '0) begin
                        err_d = 1'b0;
                    end
`endif
                    if (cnt == LAST_BEAT) begin
                        if (par_ok) begin
                            cfg_d   = word;
                            cset_d  = 1'b1;
                            state_d = MAC_CFG_COMMIT;
                        end else begin
                            state_d = MAC_CFG_IDLE;
                            clr     = 1'b1;
`ifdef MAC_CFG_PARITY_EN
                            err_d   = 1'b1;
`endif
                        end
                    end else begin
                        state_d = MAC_CFG_LOAD;
                    end
                end
            end
            MAC_CFG_COMMIT: begin
                state_d = MAC_CFG_IDLE;
                clr     = 1'b1;
            end
            default: begin
                state_d = MAC_CFG_IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    // State, committed word and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MAC_CFG_IDLE;
            cfg_q   <= '0;
            cset_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cset_q  <= cset_d;
        end
    end

`ifdef MAC_CFG_PARITY_EN
    // Sticky parity error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign cfg_err = err_q;
`else
    assign cfg_err = 1'b0;
`endif

    assign cfg  = cfg_q;
    assign cset = cset_q;
    assign busy = (state_q != MAC_CFG_IDLE);

endmodule
